// File: rtl/turn_signal_fsm_if.sv
// Switch inputs and state/timebase outputs of the tail-light state machine.
interface turn_signal_fsm_if;
  logic [1:0] SW;
  logic       turn_side;
  logic [2:0] CurrentState;
  logic       tick;
  logic       blink;
  logic [1:0] step;

  modport master (
    output SW, turn_side,
    input  CurrentState, tick, blink, step
  );

  modport slave (
    input  SW, turn_side,
    output CurrentState, tick, blink, step
  );
endinterface

// File: rtl/turn_signal_fsm.sv
// Tail-light state machine: synchronizes switches, runs the blink timebase and
// advances state/blink/step only on timebase ticks.
module turn_signal_fsm #(
  parameter int unsigned TICK_DIV = 12_500_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  turn_signal_fsm_if.slave        bus
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'b000,
    HAZARDS    = 3'b001,
    TURN_LEFT  = 3'b010,
    TURN_RIGHT = 3'b100
  } state_e;

  logic [1:0]       sw_s1_q, sw_s2_q;
  logic             side_s1_q, side_s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  state_e           state_q, state_d, req_c;
  logic             blink_q, blink_d;
  logic [1:0]       step_q, step_d;

  // Request decode from synchronized switches; hazards take priority.
  always_comb begin
    req_c = IDLE;
    if (sw_s2_q[1])      req_c = HAZARDS;
    else if (sw_s2_q[0]) req_c = side_s2_q ? TURN_RIGHT : TURN_LEFT;
  end

  always_comb begin
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    tick_d  = (cnt_q == CNT_LAST);
    state_d = state_q;
    blink_d = blink_q;
    step_d  = step_q;
    if (tick_q) begin
      if (req_c != state_q) begin
        state_d = req_c;
        step_d  = 2'd0;
        blink_d = (req_c != IDLE);
      end else if (state_q != IDLE) begin
        step_d  = step_q + 2'd1;
        blink_d = ~blink_q;
      end else begin
        step_d  = 2'd0;
        blink_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_q   <= 2'b00;
      sw_s2_q   <= 2'b00;
      side_s1_q <= 1'b0;
      side_s2_q <= 1'b0;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      state_q   <= IDLE;
      blink_q   <= 1'b0;
      step_q    <= 2'd0;
    end else begin
      sw_s1_q   <= bus.SW;
      sw_s2_q   <= sw_s1_q;
      side_s1_q <= bus.turn_side;
      side_s2_q <= side_s1_q;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      state_q   <= state_d;
      blink_q   <= blink_d;
      step_q    <= step_d;
    end
  end

  assign bus.CurrentState = state_q;
  assign bus.tick         = tick_q;
  assign bus.blink        = blink_q;
  assign bus.step         = step_q;

endmodule

// File: tb/tb_turn_signal_fsm.sv
// Directed bench for turn_signal_fsm with TICK_DIV=4.
module tb_turn_signal_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fails  = 0;

  turn_signal_fsm_if bus ();

  turn_signal_fsm #(.TICK_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sw;
    logic       side;
    logic [2:0] exp_state;
    logic       exp_blink;
    logic [1:0] exp_step;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns at the falling edge right after the state-update edge.
  task automatic wait_update();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.tick === 1'b1) seen = 1;
    end
    if (!seen) begin
      n_checks++;
      n_fails++;
      $display("FAIL tick_timeout: no tick within 20 cycles");
    end
    @(negedge clk);
  endtask

  task automatic check_outs(input string name, input logic [2:0] st,
                            input logic bl, input logic [1:0] sp);
    check({name, "_state"}, 32'(bus.CurrentState), 32'(st));
    check({name, "_blink"}, 32'(bus.blink), 32'(bl));
    check({name, "_step"},  32'(bus.step), 32'(sp));
  endtask

  initial begin
    vecs[0]  = '{2'b01, 1'b0, 3'b010, 1'b1, 2'd0};
    vecs[1]  = '{2'b01, 1'b0, 3'b010, 1'b0, 2'd1};
    vecs[2]  = '{2'b01, 1'b0, 3'b010, 1'b1, 2'd2};
    vecs[3]  = '{2'b01, 1'b0, 3'b010, 1'b0, 2'd3};
    vecs[4]  = '{2'b01, 1'b0, 3'b010, 1'b1, 2'd0};
    vecs[5]  = '{2'b11, 1'b1, 3'b001, 1'b1, 2'd0};
    vecs[6]  = '{2'b01, 1'b1, 3'b100, 1'b1, 2'd0};
    vecs[7]  = '{2'b01, 1'b1, 3'b100, 1'b0, 2'd1};
    vecs[8]  = '{2'b00, 1'b1, 3'b000, 1'b0, 2'd0};
    vecs[9]  = '{2'b00, 1'b0, 3'b000, 1'b0, 2'd0};
    vecs[10] = '{2'b10, 1'b0, 3'b001, 1'b1, 2'd0};
    vecs[11] = '{2'b00, 1'b0, 3'b000, 1'b0, 2'd0};

    bus.SW = 2'b00;
    bus.turn_side = 1'b0;
    repeat (3) @(negedge clk);
    check_outs("reset", 3'b000, 1'b0, 2'd0);
    check("reset_tick", 32'(bus.tick), 32'd0);
    rst_n = 1'b1;

    // Free-running timebase while idle: tick every 4th cycle, one cycle wide.
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check($sformatf("tick_c%0d", k), 32'(bus.tick), 32'((k % 4) == 0));
    end
    check_outs("idle_hold", 3'b000, 1'b0, 2'd0);

    wait_update();
    for (int i = 0; i < 12; i++) begin
      bus.SW = vecs[i].sw;
      bus.turn_side = vecs[i].side;
      wait_update();
      check_outs($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_blink,
                 vecs[i].exp_step);
    end

    // Glitch: SW[0] high for 2 cycles starting at a tick, gone before the next.
    begin
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (bus.tick === 1'b1) seen = 1;
      end
      check("glitch_align", 32'(seen), 32'd1);
    end
    bus.SW = 2'b01;
    repeat (2) @(negedge clk);
    bus.SW = 2'b00;
    wait_update();
    check_outs("glitch1", 3'b000, 1'b0, 2'd0);
    wait_update();
    check_outs("glitch2", 3'b000, 1'b0, 2'd0);

    // Async reset mid-run with TURN_LEFT, step=2.
    bus.SW = 2'b01;
    bus.turn_side = 1'b0;
    repeat (3) wait_update();
    check_outs("pre_rst", 3'b010, 1'b1, 2'd2);
    #2 rst_n = 1'b0;
    #1 check_outs("async_rst", 3'b000, 1'b0, 2'd0);
    bus.SW = 2'b00;
    @(negedge clk);
    check_outs("rst_hold", 3'b000, 1'b0, 2'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("post_rst_tick_c%0d", k), 32'(bus.tick), 32'(k == 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
